// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if: handshake and operand/result bundle for chunked_addsub.
//   master : drives start, sub, c_in, a, b; observes busy, done, result and flags
//   slave  : the adder side of the same signals
//   WIDTH  : operand/result width, must match the attached adder
interface chunked_addsub_if #(parameter int WIDTH = 32);
  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (output start, sub, c_in, a, b,
                  input  busy, done, result, c_out, overflow, zero);
  modport slave  (input  start, sub, c_in, a, b,
                  output busy, done, result, c_out, overflow, zero);
endinterface

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle add/subtract, CHUNK bits per clock, LS chunk first.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, aborts any operation
//   bus     : slave side of chunked_addsub_if
//             start/sub/c_in/a/b sampled only when accepted (busy=0)
//             busy high while running, done one-cycle pulse at completion
//             result/c_out/overflow/zero held between completions
// Latency is N = WIDTH/CHUNK cycles from the acceptance edge to done.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  chunked_addsub_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK:0]   w_sum;
  logic             w_c_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Chunk adder; w_sum[CHUNK] is the chunk carry-out.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit of this chunk, recovered from its sum bit.
  // Only meaningful on the last chunk, where that bit is the word MSB.
  assign w_c_msb = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
  assign w_last  = (r_cnt == CW'(N - 1));

  // Completed chunks collect at the top of a shift register; the final chunk
  // lands straight in the output so the register needs only WIDTH-CHUNK bits.
  if (N == 1) begin : g_single
    assign w_res_next = w_sum[CHUNK-1:0];
  end else begin : g_multi
    logic [WIDTH-CHUNK-1:0] r_res_sh;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              r_res_sh <= '0;
      else if (r_state == S_RUN) r_res_sh <= w_res_next[WIDTH-1:CHUNK];
    end
    assign w_res_next = {w_sum[CHUNK-1:0], r_res_sh};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            // a - b is done as a + ~b + 1
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.c_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_res_next;
            r_c_out  <= w_sum[CHUNK];
            r_ovf    <= w_sum[CHUNK] ^ w_c_msb;
            r_zero   <= (w_res_next == '0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.c_out    = r_c_out;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: directed + random checks of chunked_addsub in three
// configurations: k=0 16/4, k=1 32/8, k=2 8/8.
module tb_chunked_addsub;
  logic clk;
  logic rst_n;
  int   ncmp  = 0;
  int   nfail = 0;

  chunked_addsub_if #(.WIDTH(16)) if0 ();
  chunked_addsub_if #(.WIDTH(32)) if1 ();
  chunked_addsub_if #(.WIDTH(8))  if2 ();

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  chunked_addsub #(.WIDTH(32), .CHUNK(8)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  chunked_addsub #(.WIDTH(8),  .CHUNK(8)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int k);
    return (k == 0) ? 16 : (k == 1) ? 32 : 8;
  endfunction

  function automatic int nch(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // Reference: plain integer arithmetic. Returns {result, c_out, overflow, zero}.
  function automatic logic [34:0] ref_op(input int k, input logic [31:0] a, b,
                                         input logic s, ci);
    longint m, ua, ub, u, sa, sb, sr;
    logic [31:0] r;
    logic c, o;
    m  = longint'(1) << wid(k);
    ua = longint'({32'b0, a}) & (m - 1);
    ub = longint'({32'b0, b}) & (m - 1);
    u  = s ? (ua - ub) : (ua + ub + longint'(ci));
    c  = s ? (ua >= ub) : (u >= m);
    r  = 32'((u + m) % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = s ? (sa - sb) : (sa + sb + longint'(ci));
    o  = (sr < -(m / 2)) || (sr >= m / 2);
    return {r, c, o, (r == 32'd0)};
  endfunction

  // {busy, done, result(zero-extended), c_out, overflow, zero}
  function automatic logic [36:0] obs(input int k);
    case (k)
      0:       return {if0.busy, if0.done, 16'h0, if0.result, if0.c_out, if0.overflow, if0.zero};
      1:       return {if1.busy, if1.done, if1.result, if1.c_out, if1.overflow, if1.zero};
      default: return {if2.busy, if2.done, 24'h0, if2.result, if2.c_out, if2.overflow, if2.zero};
    endcase
  endfunction

  task automatic drive(input int k, input logic st, s, ci, input logic [31:0] a, b);
    case (k)
      0: begin if0.start = st; if0.sub = s; if0.c_in = ci; if0.a = a[15:0]; if0.b = b[15:0]; end
      1: begin if1.start = st; if1.sub = s; if1.c_in = ci; if1.a = a;       if1.b = b;       end
      default: begin if2.start = st; if2.sub = s; if2.c_in = ci; if2.a = a[7:0]; if2.b = b[7:0]; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] o, e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One operation with operand scrambling while busy; checks latency,
  // busy/done timing, result, flags and that they hold afterwards.
  task automatic do_op(input int k, input logic [31:0] a, b, input logic s, ci);
    logic [34:0] e;
    logic [36:0] ob;
    int lat;
    e = ref_op(k, a, b, s, ci);
    @(negedge clk); drive(k, 1'b1, s, ci, a, b);
    @(negedge clk); drive(k, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
    ob = obs(k);
    chk($sformatf("k%0d_busy_accept", k), 64'(ob[36]), 64'd1);
    lat = 0;
    while (ob[35] !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++; ob = obs(k);
    end
    chk($sformatf("k%0d_latency", k), 64'(lat), 64'(nch(k)));
    chk($sformatf("k%0d_busy_done", k), 64'(ob[36]), 64'd0);
    chk($sformatf("k%0d_result a=%h b=%h s=%b c=%b", k, a, b, s, ci), 64'(ob[34:3]), 64'(e[34:3]));
    chk($sformatf("k%0d_flags a=%h b=%h s=%b c=%b", k, a, b, s, ci), 64'(ob[2:0]), 64'(e[2:0]));
    @(negedge clk); ob = obs(k);
    chk($sformatf("k%0d_done_pulse", k), 64'(ob[35]), 64'd0);
    chk($sformatf("k%0d_hold", k), 64'(ob[34:0]), 64'(e));
  endtask

  initial begin
    logic [36:0] ob;
    logic [34:0] e1, e2;
    int t1, t2;
    logic seen;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ob = obs(k);
      chk($sformatf("k%0d_reset_state", k), 64'(ob), 64'd0);
    end
    rst_n = 1'b1;

    // Directed arithmetic in every configuration
    for (int k = 0; k < 3; k++) begin
      do_op(k, 32'h1234, 32'h4321, 1'b0, 1'b0);
      do_op(k, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
      do_op(k, 32'h8000, 32'h0001, 1'b1, 1'b0);
      do_op(k, 32'h0001, 32'h0002, 1'b1, 1'b1);
    end
    do_op(1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    do_op(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    do_op(2, 32'h7F, 32'h01, 1'b0, 1'b0);

    // start held high: the request during busy is ignored, the one on the
    // done-visible cycle is accepted, completions 5 cycles apart.
    @(negedge clk); drive(0, 1'b1, 1'b0, 1'b0, 32'h1111, 32'h2222);
    e1 = ref_op(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
    @(negedge clk); drive(0, 1'b1, 1'b1, 1'b0, 32'h0005, 32'h0009);
    e2 = ref_op(0, 32'h0005, 32'h0009, 1'b1, 1'b0);
    t1 = -1; t2 = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk); ob = obs(0);
      if (n == 5) drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (ob[35] === 1'b1) begin
        if (t1 < 0) begin t1 = n; chk("b2b_first", 64'(ob[34:0]), 64'(e1)); end
        else if (t2 < 0) begin t2 = n; chk("b2b_second", 64'(ob[34:0]), 64'(e2)); end
      end
    end
    chk("b2b_first_time", 64'(t1), 64'd4);
    chk("b2b_second_time", 64'(t2), 64'd9);

    // Reset in the middle of an operation
    @(negedge clk); drive(0, 1'b1, 1'b0, 1'b0, 32'hAAAA, 32'h1111);
    @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1; ob = obs(0);
    chk("reset_abort_async", 64'(ob), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); ob = obs(0);
      seen = seen | ob[35];
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    do_op(0, 32'h00FF, 32'h0F01, 1'b0, 1'b1);

    // Random regression
    for (int k = 0; k < 3; k++)
      repeat (15) do_op(k, $urandom, $urandom, 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
